// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_sb
// Purpose  : Parametrised MIPS register file with write-first bypass,
//            selectable read latency and a per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int READ_LAT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pend_en,
    input  logic [ADDR_W-1:0]        pend_addr,
    input  logic                     flush
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_busy_next;
    logic               w_wr_ok;
    logic               w_pend_ok;

    assign w_wr_ok   = wr_en   && (wr_addr   != '0);
    assign w_pend_ok = pend_en && (pend_addr != '0);

    // Entry 0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Later assignments win: write-clear, then flush, then pend-set.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (flush) begin
            w_busy_next = '0;
        end
        if (w_pend_ok) begin
            w_busy_next[pend_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];
        assign w_hit  = w_wr_ok && (w_addr == wr_addr);
        // Also the post-edge contents of the addressed register.
        assign w_data = w_hit ? wr_data : r_mem[w_addr];

        if (READ_LAT == 0) begin : g_comb
            assign rd_data[p*DATA_W +: DATA_W] = w_data;
            assign rd_busy[p]                  = r_busy[w_addr] & ~w_hit;
        end else begin : g_reg
            logic [DATA_W-1:0] r_data;
            logic              r_bsy;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data <= '0;
                    r_bsy  <= 1'b0;
                end else begin
                    r_data <= w_data;
                    r_bsy  <= w_busy_next[w_addr];
                end
            end

            assign rd_data[p*DATA_W +: DATA_W] = r_data;
            assign rd_busy[p]                  = r_bsy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_sb
// Purpose  : Bench for mips_regfile_sb; a combinational 2-port instance and a
//            registered 4-port instance share one stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_mips_regfile_sb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [19:0]  rd_addr = '0;
    logic [63:0]  d0;
    logic [1:0]   b0;
    logic [127:0] d1;
    logic [3:0]   b1;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic         pend_en = 1'b0;
    logic [4:0]   pend_addr = '0;
    logic         flush = 1'b0;
    logic         chk_on = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .READ_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr[9:0]), .rd_data(d0), .rd_busy(b0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_en(pend_en), .pend_addr(pend_addr), .flush(flush)
    );

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .READ_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(d1), .rd_busy(b1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_en(pend_en), .pend_addr(pend_addr), .flush(flush)
    );

    // Reference: architectural register and busy arrays.
    logic [31:0] m_reg  [32];
    logic        m_busy [32];
    logic [31:0] e1_data [4];
    logic        e1_busy [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 1'b0;
            end
            for (int p = 0; p < 4; p++) begin
                e1_data[p] = '0;
                e1_busy[p] = 1'b0;
            end
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_reg[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end
            if (pend_en && pend_addr != 0) m_busy[pend_addr] = 1'b1;
            for (int p = 0; p < 4; p++) begin
                e1_data[p] = m_reg[rd_addr[p*5 +: 5]];
                e1_busy[p] = m_busy[rd_addr[p*5 +: 5]];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int p = 0; p < 2; p++) begin
                logic [4:0]  a;
                logic        hit;
                a   = rd_addr[p*5 +: 5];
                hit = wr_en && (wr_addr != 0) && (a == wr_addr);
                chk($sformatf("lat0_data[%0d]", p), d0[p*32 +: 32], hit ? wr_data : m_reg[a]);
                chk($sformatf("lat0_busy[%0d]", p), {31'b0, b0[p]}, {31'b0, hit ? 1'b0 : m_busy[a]});
            end
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("lat1_data[%0d]", p), d1[p*32 +: 32], e1_data[p]);
                chk($sformatf("lat1_busy[%0d]", p), {31'b0, b1[p]}, {31'b0, e1_busy[p]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        pend_en = 1'b0;
        flush   = 1'b0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        @(posedge clk);
        #1;
        chk_on = 1'b1;

        // Reset: every address reads zero and not busy.
        for (int a = 0; a < 32; a++) begin
            step();
            rd_addr = {4{5'(a)}};
            @(negedge clk);
            chk("rst_lat0_data", d0[31:0], 32'h0);
            chk("rst_lat0_busy", {30'b0, b0}, 32'h0);
            chk("rst_lat1_data", d1[127:96], 32'h0);
        end

        step();
        rst_n = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000000A; rd_addr = '0;
        step();
        wr_en = 1'b0; rd_addr = {4{5'd5}};
        @(negedge clk);
        chk("first_write_lat0", d0[31:0], 32'h0000000A);
        chk("model_r5", m_reg[5], 32'h0000000A);
        step();
        @(negedge clk);
        chk("first_write_lat1", d1[31:0], 32'h0000000A);

        // Register zero ignores write and pend.
        step();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000000A;
        pend_en = 1'b1; pend_addr = 5'd0; rd_addr = '0;
        @(negedge clk);
        chk("r0_same_data", d0[63:0], 64'h0);
        chk("r0_same_busy", {30'b0, b0}, 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("r0_after_lat0", d0[31:0], 32'h0);
        chk("r0_after_lat1", d1[127:96], 32'h0);
        chk("r0_after_busy1", {28'b0, b1}, 32'h0);

        // Write-first bypass on both combinational ports.
        step();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h11111111;
        step();
        wr_data = 32'h22222222; rd_addr = {4{5'd10}};
        @(negedge clk);
        chk("bypass_p0", d0[31:0], 32'h22222222);
        chk("bypass_p1", d0[63:32], 32'h22222222);
        chk("bypass_busy", {30'b0, b0}, 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("bypass_lat1_p3", d1[127:96], 32'h22222222);

        // Scoreboard set, clear by write, and pend beating a write.
        step();
        pend_en = 1'b1; pend_addr = 5'd7;
        step();
        pend_en = 1'b0; rd_addr = {4{5'd7}};
        @(negedge clk);
        chk("sb_pend_busy", {31'b0, b0[0]}, 32'h1);
        chk("model_busy7", {31'b0, m_busy[7]}, 32'h1);
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5;
        @(negedge clk);
        chk("sb_wr_bypass_busy", {31'b0, b0[0]}, 32'h0);
        chk("sb_wr_bypass_data", d0[31:0], 32'h5);
        chk("sb_lat1_busy", {31'b0, b1[0]}, 32'h1);
        step();
        pend_en = 1'b1; pend_addr = 5'd7;
        @(negedge clk);
        chk("sb_wr_cleared_lat1", {31'b0, b1[0]}, 32'h0);
        chk("sb_both_comb_busy", {31'b0, b0[0]}, 32'h0);
        step();
        idle();
        @(negedge clk);
        chk("sb_pend_wins_busy", {31'b0, b0[0]}, 32'h1);
        chk("sb_pend_wins_data", d0[31:0], 32'h5);
        chk("sb_pend_wins_lat1", {31'b0, b1[0]}, 32'h1);

        // Flush clears everything except a same-edge pend.
        step();
        pend_en = 1'b1; pend_addr = 5'd3;
        step();
        pend_addr = 5'd4;
        step();
        pend_addr = 5'd9; rd_addr = {5'd7, 5'd9, 5'd4, 5'd3};
        @(negedge clk);
        chk("fl_busy_before", {30'b0, b0}, 32'h3);
        step();
        pend_addr = 5'd4; flush = 1'b1;
        step();
        idle();
        @(negedge clk);
        chk("fl_busy_after", {30'b0, b0}, 32'h2);
        chk("fl_lat1_busy", {28'b0, b1}, 32'h2);
        chk("fl_data_kept", d1[127:96], 32'h5);

        // Registered read of a same-edge write, then asynchronous reset.
        step();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hDEADBEEF; rd_addr = {4{5'd2}};
        @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 4; p++) chk($sformatf("lat1_wr_p%0d", p), d1[p*32 +: 32], 32'hDEADBEEF);
        #2;
        wr_en = 1'b0; rst_n = 1'b0;
        #1;
        chk("async_rst_lat1_data", d1[31:0] | d1[63:32] | d1[95:64] | d1[127:96], 32'h0);
        chk("async_rst_lat1_busy", {28'b0, b1}, 32'h0);
        chk("async_rst_lat0_data", d0[31:0], 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Randomised traffic against the reference model.
        repeat (2000) begin
            step();
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = rnd_addr();
            wr_data   = $urandom;
            pend_en   = ($urandom_range(0, 2) == 0);
            pend_addr = rnd_addr();
            flush     = ($urandom_range(0, 15) == 0);
            rd_addr   = {rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()};
        end
        step();
        idle();
        step();
        @(negedge clk);
        chk_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
